// File: rtl/matrix_mul_pkg.sv
// Shared types and helpers for the time-multiplexed matrix multiplier.
package matrix_mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Widest operand/accumulator the extension helper can handle.
  localparam int EXT_W = 64;

  // Result width that can hold a full dot product without overflow.
  function automatic int acc_width(input int bits, input int width);
    return 2 * bits + $clog2(width);
  endfunction

  // Sign- or zero-extends the low 'bits' bits of value to EXT_W bits.
  function automatic logic [EXT_W-1:0] extend(input logic [EXT_W-1:0] value,
                                              input int bits,
                                              input logic signed_mode);
    logic [EXT_W-1:0] r;
    logic msb;
    msb = 1'b0;
    for (int i = 0; i < EXT_W; i++) begin
      if (i == bits - 1) msb = value[i];
    end
    for (int i = 0; i < EXT_W; i++) begin
      r[i] = (i < bits) ? value[i] : (msb & signed_mode);
    end
    return r;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One multiply-accumulate lane: operands are extended to ACC_W before the
// multiply so the same adder serves signed and unsigned modes.
module mac_lane import matrix_mul_pkg::*; #(
  parameter int BITS  = 4,
  parameter int ACC_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic             signed_mode,
  input  logic [BITS-1:0]  a,
  input  logic [BITS-1:0]  b,
  output logic [ACC_W-1:0] acc_next,
  output logic [ACC_W-1:0] acc
);

  logic signed [ACC_W-1:0] a_ext;
  logic signed [ACC_W-1:0] b_ext;
  logic signed [ACC_W-1:0] product;

  // Extend both operands, multiply modulo 2^ACC_W and add to the running sum.
  always_comb begin
    a_ext    = ACC_W'(extend(EXT_W'(a), BITS, signed_mode));
    b_ext    = ACC_W'(extend(EXT_W'(b), BITS, signed_mode));
    product  = a_ext * b_ext;
    acc_next = acc + ACC_W'($unsigned(product));
  end

  // Running sum; the final term is consumed by the caller via acc_next, so the
  // register clears on that same edge ready for the next element.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (en) begin
      acc <= clear ? '0 : acc_next;
    end
  end

endmodule

// File: rtl/matrix_mul_seq.sv
// Sequential matrix multiplier C = A x B sharing LANES MAC lanes across all
// output elements; each group of LANES elements takes WIDTH cycles.
module matrix_mul_seq import matrix_mul_pkg::*; #(
  parameter  int BITS     = 4,
  parameter  int WIDTH    = 3,
  parameter  int HEIGHT_A = 2,
  parameter  int WIDTH_B  = 3,
  parameter  int LANES    = 2,
  localparam int ACC_W    = acc_width(BITS, WIDTH)
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      i_start,
  input  logic                                      i_signed,
  input  logic [HEIGHT_A-1:0][WIDTH-1:0][BITS-1:0]  i_array_a,
  input  logic [WIDTH-1:0][WIDTH_B-1:0][BITS-1:0]   i_array_b,
  output logic                                      o_busy,
  output logic                                      o_done,
  output logic [HEIGHT_A-1:0][WIDTH_B-1:0][ACC_W-1:0] o_array_res
);

  localparam int ELEMS  = HEIGHT_A * WIDTH_B;
  localparam int GROUPS = (ELEMS + LANES - 1) / LANES;
  localparam int K_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GRP_W  = $clog2(GROUPS + 1);

  state_t state;
  state_t state_next;

  logic [K_W-1:0]   k;
  logic [GRP_W-1:0] grp;
  logic             accept;
  logic             last_k;
  logic             last_grp;

  logic [HEIGHT_A-1:0][WIDTH-1:0][BITS-1:0] a_q;
  logic [WIDTH-1:0][WIDTH_B-1:0][BITS-1:0]  b_q;
  logic                                     signed_q;

  logic [LANES-1:0] lane_active;
  logic [LANES-1:0] lane_en;
  int               lane_row [LANES];
  int               lane_col [LANES];
  logic [BITS-1:0]  lane_a [LANES];
  logic [BITS-1:0]  lane_b [LANES];
  logic [ACC_W-1:0] lane_acc_next [LANES];
  // The registered sum is only needed inside each lane.
  logic [ACC_W-1:0] acc_unused [LANES];

  assign last_k   = (int'(k) == WIDTH - 1);
  assign last_grp = (int'(grp) == GROUPS - 1);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs; busy covers RUN and the DONE pulse.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    o_busy     = 1'b0;
    o_done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        o_busy = 1'b1;
        if (last_k && last_grp) state_next = DONE;
      end
      DONE: begin
        o_busy     = 1'b1;
        o_done     = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand latch and k/grp sequencing; inputs are ignored outside acceptance.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      k        <= '0;
      grp      <= '0;
    end else if (accept) begin
      a_q      <= i_array_a;
      b_q      <= i_array_b;
      signed_q <= i_signed;
      k        <= '0;
      grp      <= '0;
    end else if (state == RUN) begin
      if (last_k) begin
        k   <= '0;
        grp <= grp + GRP_W'(1);
      end else begin
        k <= k + K_W'(1);
      end
    end
  end

  // Map each lane to its output element and select its A/B operands for this k.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_row[l]    = (int'(grp) * LANES + l) / WIDTH_B;
      lane_col[l]    = (int'(grp) * LANES + l) % WIDTH_B;
      lane_active[l] = ((int'(grp) * LANES + l) < ELEMS);
      lane_en[l]     = (state == RUN) && lane_active[l];
      lane_a[l]      = '0;
      lane_b[l]      = '0;
      for (int r = 0; r < HEIGHT_A; r++) begin
        for (int c = 0; c < WIDTH; c++) begin
          if (r == lane_row[l] && c == int'(k)) lane_a[l] = a_q[r][c];
        end
      end
      for (int kk = 0; kk < WIDTH; kk++) begin
        for (int c = 0; c < WIDTH_B; c++) begin
          if (kk == int'(k) && c == lane_col[l]) lane_b[l] = b_q[kk][c];
        end
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mac_lane #(
      .BITS  (BITS),
      .ACC_W (ACC_W)
    ) u_lane (
      .clk         (clk),
      .reset       (reset),
      .en          (lane_en[l]),
      .clear       (last_k),
      .signed_mode (signed_q),
      .a           (lane_a[l]),
      .b           (lane_b[l]),
      .acc_next    (lane_acc_next[l]),
      .acc         (acc_unused[l])
    );
  end

  // Result file: each active lane writes its finished dot product on the last k.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_array_res <= '0;
    end else if (state == RUN && last_k) begin
      for (int l = 0; l < LANES; l++) begin
        for (int r = 0; r < HEIGHT_A; r++) begin
          for (int c = 0; c < WIDTH_B; c++) begin
            if (lane_active[l] && lane_row[l] == r && lane_col[l] == c) begin
              o_array_res[r][c] <= lane_acc_next[l];
            end
          end
        end
      end
    end
  end

endmodule

// File: doc/matrix_mul_seq.md
Name: matrix_mul_seq

Overview:
- Time-multiplexed successor to the fully parallel combinational matrix multiplier.
- Computes C = A x B for an A of HEIGHT_A x WIDTH and a B of WIDTH x WIDTH_B.
- Uses LANES shared MAC lanes instead of one MAC string per output element; trades latency for area.
- Adds a start/busy/done handshake, operand latching, a signed/unsigned mode and growth-safe accumulator width.
- Sits between the operand buffers and the result consumer in the compute datapath.

Parameters:
- BITS, 4: operand bit depth.
- WIDTH, 3: columns of A and rows of B (dot-product length), >=1.
- HEIGHT_A, 2: rows of A, >=1.
- WIDTH_B, 3: columns of B, >=1.
- LANES, 2: parallel MAC lanes, 1..HEIGHT_A*WIDTH_B.
- ACC_W, 2*BITS+$clog2(WIDTH) (derived, localparam): result width; no overflow possible.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_start  in  1  request; accepted only when o_busy==0.
- i_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled at acceptance.
- i_array_a  in  [BITS-1:0] x [HEIGHT_A][WIDTH]  matrix A; sampled at acceptance.
- i_array_b  in  [BITS-1:0] x [WIDTH][WIDTH_B]  matrix B; sampled at acceptance.
- o_busy  out  1  high from acceptance until o_done.
- o_done  out  1  one-cycle pulse; results valid.
- o_array_res  out  [ACC_W-1:0] x [HEIGHT_A][WIDTH_B]  registered result matrix.

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset (reset==0, async): state=IDLE; o_busy=0; o_done=0; all o_array_res=0; counters and accumulators 0; latched operands 0.
- IDLE:
  - i_start==1 at an edge latches A, B and i_signed; k=0, grp=0; go to RUN; o_busy=1 from that edge.
  - Otherwise remain in IDLE.
- Element mapping: flattened index e=grp*LANES+lane; row=e/WIDTH_B; col=e%WIDTH_B. Lanes with e>=HEIGHT_A*WIDTH_B are gated: no accumulate, no write.
- RUN, per edge:
  - Each active lane computes acc += A[row][k]*B[k][col], with operands sign- or zero-extended to ACC_W per the latched mode.
  - k increments each edge.
  - At k==WIDTH-1, each active lane writes acc+product to o_array_res[row][col] on the same edge; its acc clears to 0, k wraps to 0 and grp increments.
- RUN duration: G*WIDTH edges, where G=ceil(HEIGHT_A*WIDTH_B/LANES). The write edge of the last group moves to DONE.
- DONE: o_done=1 and o_busy=1 for exactly one cycle, then IDLE with o_busy=0.
- Latency: acceptance edge T gives o_done high in the cycle after edge T+G*WIDTH.
- Back-to-back: a new start can be accepted on the edge leaving DONE+1, i.e. the first edge in IDLE.
- Result visibility: o_array_res holds the previous results until overwritten element-by-element in the next run. Elements not yet written keep their old values; consumers use o_done only.
- i_start while o_busy==1: ignored, no queueing. Input changes during RUN have no effect because operands are latched.
- WIDTH==1: every group completes in one edge.
- LANES==HEIGHT_A*WIDTH_B: G=1.
- Reset asserted mid-RUN: immediate abort; all outputs return to reset values.

Decomposition:
- Package matrix_mul_pkg contains:
  - state enum (IDLE, RUN, DONE);
  - function acc_width(bits, width) returning the ACC_W formula;
  - function extend(value, signed_mode) for sign/zero extension.
- Sub-module mac_lane (BITS, ACC_W): one lane with clear, enable and signed mode; outputs acc_next combinationally and acc registered. Instantiated LANES times in a generate loop.
- Top level holds the FSM, k/grp counters, operand registers, index muxing and the result register file.

Test Plan:
1. Defaults, unsigned. A=[[1,2,3],[4,5,6]], B=[[7,8,9],[10,11,12],[13,14,15]], start at edge T -> o_done in the cycle after T+9; C=[[66,72,78],[156,171,186]]; o_busy high for 10 cycles.
2. Signed corner. i_signed=1, all A=4'h8 (-8), all B=4'h7 -> every C = -168 (10'h358). Same data with i_signed=0 gives 8*7*3=168 everywhere.
3. Max unsigned. All A=B=15 -> every C=675. Proves ACC_W=10 does not overflow.
4. Partial last group. LANES=4, defaults -> G=2, o_done after 6 edges, results as in test 1, no spurious writes from the gated lanes.
5. Protocol. i_start held high for 30 cycles -> runs accepted at T and T+11 only. Changing A during RUN does not alter C.
6. Reset mid-run. Drop reset at edge T+4 -> o_busy=0, o_done=0, all C=0 immediately. A restart after release gives correct results.
